// File: rtl/bp_nonsynth_commit_driver_if.sv
// bp_nonsynth_commit_driver_if: record handshake plus commit/writeback bundle of the commit driver
interface bp_nonsynth_commit_driver_if #(
    parameter int vaddr_width_p = 39,
    parameter int dword_width_p = 64,
    parameter int late_els_p    = 4
);
    localparam int pend_w = $clog2(late_els_p + 1);
    logic                     rec_v_i;
    logic                     rec_ready_o;
    logic                     rec_exc_i;
    logic [vaddr_width_p-1:0] rec_pc_i;
    logic [31:0]              rec_instr_i;
    logic                     rec_iw_i;
    logic                     rec_fw_i;
    logic                     rec_late_i;
    logic [dword_width_p-1:0] rec_data_i;
    logic                     instret_o;
    logic                     exception_o;
    logic [vaddr_width_p-1:0] pc_o;
    logic [31:0]              instr_o;
    logic                     ird_w_v_o;
    logic [4:0]               ird_addr_o;
    logic [dword_width_p-1:0] ird_data_o;
    logic                     frd_w_v_o;
    logic [4:0]               frd_addr_o;
    logic [dword_width_p-1:0] frd_data_o;
    logic [pend_w-1:0]        pending_o;

    modport master (
        output rec_v_i, rec_exc_i, rec_pc_i, rec_instr_i, rec_iw_i, rec_fw_i, rec_late_i, rec_data_i,
        input  rec_ready_o, instret_o, exception_o, pc_o, instr_o, ird_w_v_o, ird_addr_o, ird_data_o,
               frd_w_v_o, frd_addr_o, frd_data_o, pending_o
    );
    modport slave (
        input  rec_v_i, rec_exc_i, rec_pc_i, rec_instr_i, rec_iw_i, rec_fw_i, rec_late_i, rec_data_i,
        output rec_ready_o, instret_o, exception_o, pc_o, instr_o, ird_w_v_o, ird_addr_o, ird_data_o,
               frd_w_v_o, frd_addr_o, frd_data_o, pending_o
    );
endinterface

// File: rtl/bp_nonsynth_commit_driver.sv
// bp_nonsynth_commit_driver: replays instruction records as commit packets with early and late writebacks
module bp_nonsynth_commit_driver #(
    parameter int vaddr_width_p = 39,
    parameter int dword_width_p = 64,
    parameter int late_lat_p    = 3,
    parameter int late_els_p    = 4
) (
    input logic clk_i,
    input logic reset_n_i,
    bp_nonsynth_commit_driver_if.slave io
);
    localparam int pw = late_els_p > 1 ? $clog2(late_els_p) : 1;
    localparam int cw = $clog2(late_els_p + 1);
    localparam int lw = $clog2(late_lat_p + 1);

    logic [late_els_p-1:0]    q_f, q_v;
    logic [4:0]               q_rd   [late_els_p];
    logic [dword_width_p-1:0] q_data [late_els_p];
    logic [lw-1:0]            q_cnt  [late_els_p];
    logic [pw-1:0]            rptr, wptr;
    logic [cw-1:0]            occ;
    logic                     c_v, c_exc, c_iw, c_fw;
    logic [vaddr_width_p-1:0] c_pc;
    logic [31:0]              c_instr;
    logic [4:0]               c_rd;
    logic [dword_width_p-1:0] c_data;
    logic [4:0]               rd;
    logic                     wr, early, haz, conf, ready, acc, push, issue, li, lf;

    assign rd    = io.rec_instr_i[11:7];
    assign wr    = (io.rec_iw_i | io.rec_fw_i) & ~io.rec_exc_i;
    assign early = wr & ~io.rec_late_i;

    for (genvar i = 0; i < late_els_p; i++) begin : g_v
        logic [pw-1:0] off;
        assign off    = pw'(i) - rptr;
        assign q_v[i] = cw'(off) < occ;
    end

    always_comb begin
        haz  = 1'b0;
        conf = 1'b0;
        for (int i = 0; i < late_els_p; i++) begin
            haz  = haz | (q_v[i] & (q_f[i] == io.rec_fw_i) & (q_rd[i] == rd));
            // counts rise strictly from the head, so cnt<=1 covers every entry able to issue next cycle
            conf = conf | (q_v[i] & (q_f[i] == io.rec_fw_i) & (q_cnt[i] <= lw'(1)));
        end
    end

    assign ready          = reset_n_i & (occ != cw'(late_els_p)) & ~(wr & haz) & ~(early & conf);
    assign io.rec_ready_o = ready;
    assign acc            = io.rec_v_i & ready;
    assign push           = acc & wr & io.rec_late_i;
    assign issue          = (occ != '0) & (q_cnt[rptr] == '0);
    assign li             = issue & ~q_f[rptr];
    assign lf             = issue & q_f[rptr];

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rptr    <= '0;
            wptr    <= '0;
            occ     <= '0;
            c_v     <= 1'b0;
            c_exc   <= 1'b0;
            c_iw    <= 1'b0;
            c_fw    <= 1'b0;
            c_pc    <= '0;
            c_instr <= '0;
            c_rd    <= '0;
            c_data  <= '0;
        end else begin
            rptr <= rptr + pw'(issue);
            wptr <= wptr + pw'(push);
            occ  <= occ + cw'(push) - cw'(issue);
            for (int i = 0; i < late_els_p; i++)
                q_cnt[i] <= (q_cnt[i] == '0) ? '0 : q_cnt[i] - lw'(1);
            if (push) begin
                q_f[wptr]    <= io.rec_fw_i;
                q_rd[wptr]   <= rd;
                q_data[wptr] <= io.rec_data_i;
                q_cnt[wptr]  <= lw'(late_lat_p);
            end
            c_v     <= acc;
            c_exc   <= acc & io.rec_exc_i;
            c_iw    <= acc & early & ~io.rec_fw_i;
            c_fw    <= acc & early & io.rec_fw_i;
            c_pc    <= acc ? io.rec_pc_i : '0;
            c_instr <= acc ? io.rec_instr_i : '0;
            c_rd    <= (acc & early) ? rd : '0;
            c_data  <= (acc & early) ? io.rec_data_i : '0;
        end
    end

    // a due late writeback owns its port; the stall rules keep the early one off that port
    assign io.instret_o   = c_v & ~c_exc;
    assign io.exception_o = c_exc;
    assign io.pc_o        = c_pc;
    assign io.instr_o     = c_instr;
    assign io.ird_w_v_o   = li | c_iw;
    assign io.ird_addr_o  = li ? q_rd[rptr] : c_iw ? c_rd : '0;
    assign io.ird_data_o  = li ? q_data[rptr] : c_iw ? c_data : '0;
    assign io.frd_w_v_o   = lf | c_fw;
    assign io.frd_addr_o  = lf ? q_rd[rptr] : c_fw ? c_rd : '0;
    assign io.frd_data_o  = lf ? q_data[rptr] : c_fw ? c_data : '0;
    assign io.pending_o   = occ;

    a_iw_fw : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(io.rec_v_i && io.rec_iw_i && io.rec_fw_i));
endmodule

// File: tb/tb_bp_nonsynth_commit_driver.sv
// tb_bp_nonsynth_commit_driver: directed and random records checked against a pending-write timeline model
module tb_bp_nonsynth_commit_driver;
    localparam int LAT = 3;
    localparam int ELS = 4;

    typedef struct {
        bit exc, iw, fw, late;
        logic [38:0] pc;
        logic [31:0] instr;
        logic [63:0] data;
    } rec_t;
    typedef struct {
        bit f;
        logic [4:0] rd;
        logic [63:0] d;
        int acc;
        int iss;
    } ent_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0, failures = 0, cyc = 0, last_iss = -100;
    ent_t q[$];
    rec_t p;
    bit pv = 1'b0;

    always #5 clk = ~clk;

    bp_nonsynth_commit_driver_if #(.vaddr_width_p(39), .dword_width_p(64), .late_els_p(ELS)) io();
    bp_nonsynth_commit_driver #(.vaddr_width_p(39), .dword_width_p(64), .late_lat_p(LAT), .late_els_p(ELS))
        dut (.clk_i(clk), .reset_n_i(reset_n), .io(io));

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, e);
        end
    endtask

    function automatic rec_t mkr(bit exc, bit iw, bit fw, bit late, logic [4:0] rd, logic [63:0] d);
        rec_t r;
        r.exc = exc; r.iw = iw; r.fw = fw; r.late = late;
        r.pc = 39'({$urandom(), $urandom()});
        r.instr = {20'($urandom()), rd, 7'h03};
        r.data = d;
        return r;
    endfunction

    // a late write occupies the queue from the cycle after acceptance through its issue cycle
    function automatic bit model_ready(rec_t r);
        int occ = 0;
        bit wr = (r.iw || r.fw) && !r.exc;
        bit blk = 1'b0;
        foreach (q[i]) if (q[i].acc < cyc && q[i].iss >= cyc) begin
            occ++;
            if (wr && q[i].f == r.fw && q[i].rd == r.instr[11:7]) blk = 1'b1;
            if (wr && !r.late && q[i].f == r.fw && q[i].iss <= cyc + 1) blk = 1'b1;
        end
        return occ < ELS && !blk;
    endfunction

    task automatic check_outputs();
        bit lv = 1'b0, ei, ef, li, lf;
        ent_t le;
        int pend = 0;
        for (int i = q.size() - 1; i >= 0; i--) if (q[i].iss < cyc) q.delete(i);
        foreach (q[i]) begin
            if (q[i].acc < cyc) pend++;
            if (q[i].iss == cyc) begin lv = 1'b1; le = q[i]; end
        end
        ei = pv && p.iw && !p.late && !p.exc;
        ef = pv && p.fw && !p.late && !p.exc;
        li = lv && !le.f;
        lf = lv && le.f;
        chk("instret", io.instret_o, pv && !p.exc);
        chk("exception", io.exception_o, pv && p.exc);
        chk("pc", io.pc_o, pv ? p.pc : 39'd0);
        chk("instr", io.instr_o, pv ? p.instr : 32'd0);
        chk("ird_w_v", io.ird_w_v_o, li || ei);
        chk("ird_addr", io.ird_addr_o, li ? le.rd : ei ? p.instr[11:7] : 5'd0);
        chk("ird_data", io.ird_data_o, li ? le.d : ei ? p.data : 64'd0);
        chk("frd_w_v", io.frd_w_v_o, lf || ef);
        chk("frd_addr", io.frd_addr_o, lf ? le.rd : ef ? p.instr[11:7] : 5'd0);
        chk("frd_data", io.frd_data_o, lf ? le.d : ef ? p.data : 64'd0);
        chk("pending", io.pending_o, pend);
    endtask

    task automatic step(input bit rn, input bit v, input rec_t r, output bit acc);
        bit er;
        int t = cyc, iss;
        reset_n = rn;
        io.rec_v_i = v; io.rec_exc_i = r.exc; io.rec_pc_i = r.pc; io.rec_instr_i = r.instr;
        io.rec_iw_i = r.iw; io.rec_fw_i = r.fw; io.rec_late_i = r.late; io.rec_data_i = r.data;
        #1;
        er = rn && model_ready(r);
        chk("rec_ready", io.rec_ready_o, er);
        acc = v && er;
        @(posedge clk);
        cyc++;
        if (!rn) begin
            q.delete(); pv = 1'b0; last_iss = -100;
        end else begin
            pv = acc; p = r;
            if (acc && r.late && (r.iw || r.fw) && !r.exc) begin
                iss = (t + 1 + LAT > last_iss + 1) ? t + 1 + LAT : last_iss + 1;
                q.push_back('{f: r.fw, rd: r.instr[11:7], d: r.data, acc: t, iss: iss});
                last_iss = iss;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        bit a;
        rec_t z = mkr(0, 0, 0, 0, 5'd0, 64'd0);
        repeat (n) step(1, 0, z, a);
    endtask

    task automatic offer(input rec_t r, output int stalls);
        bit a = 1'b0;
        stalls = 0;
        for (int k = 0; k < 20 && !a; k++) begin
            step(1, 1, r, a);
            if (!a) stalls++;
        end
        if (!a) chk("offer_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        bit a;
        int s;
        rec_t r;
        rec_t z = mkr(0, 0, 0, 0, 5'd0, 64'd0);
        repeat (2) step(0, 0, z, a);
        chk("rst_pending", io.pending_o, 0);
        r = mkr(0, 1, 0, 0, 5'd1, 64'd5);
        r.pc = 39'h80000000; r.instr = 32'h00500093;
        step(1, 1, r, a);
        chk("t1_instret", io.instret_o, 1);
        chk("t1_ird_v", io.ird_w_v_o, 1);
        chk("t1_ird_addr", io.ird_addr_o, 1);
        chk("t1_ird_data", io.ird_data_o, 5);
        chk("t1_frd_v", io.frd_w_v_o, 0);
        step(1, 1, mkr(0, 1, 0, 1, 5'd5, 64'hDEAD), a);
        chk("t2_instret", io.instret_o, 1);
        chk("t2_pending", io.pending_o, 1);
        idle(2);
        chk("t2_early", io.ird_w_v_o, 0);
        idle(1);
        chk("t2_ird_v", io.ird_w_v_o, 1);
        chk("t2_ird_addr", io.ird_addr_o, 5);
        chk("t2_ird_data", io.ird_data_o, 64'hDEAD);
        idle(2);
        step(1, 1, mkr(0, 1, 0, 1, 5'd5, 64'h1111), a);
        offer(mkr(0, 1, 0, 0, 5'd5, 64'h55), s);
        chk("t3_stalls", s, 4);
        chk("t3_ird_data", io.ird_data_o, 64'h55);
        idle(4);
        for (int k = 0; k < 4; k++) begin
            offer(mkr(0, 0, 1, 1, 5'(10 + k), 64'(100 + k)), s);
            chk("t4_nostall", s, 0);
        end
        chk("t4_peak", io.pending_o, 4);
        offer(mkr(0, 0, 1, 1, 5'd14, 64'd104), s);
        chk("t4_full_stall", s, 1);
        idle(8);
        step(1, 1, mkr(0, 1, 0, 1, 5'd3, 64'h33), a);
        idle(2);
        offer(mkr(0, 0, 1, 0, 5'd4, 64'h44), s);
        chk("t5_fp_nostall", s, 0);
        offer(mkr(0, 1, 0, 0, 5'd4, 64'h45), s);
        chk("t5_int_stall", s, 1);
        idle(4);
        step(1, 1, mkr(0, 1, 0, 1, 5'd6, 64'h66), a);
        step(1, 1, mkr(0, 1, 0, 1, 5'd7, 64'h77), a);
        step(1, 1, mkr(1, 1, 0, 0, 5'd6, 64'h99), a);
        chk("t6_exception", io.exception_o, 1);
        chk("t6_no_wb", io.ird_w_v_o, 0);
        chk("t6_pending", io.pending_o, 2);
        step(0, 0, z, a);
        chk("t6_rst_pending", io.pending_o, 0);
        chk("t6_rst_wb", io.ird_w_v_o, 0);
        step(0, 0, z, a);
        idle(8);
        for (int k = 0; k < 800; k++) begin
            bit fw = $urandom_range(0, 1) == 1;
            bit nw = $urandom_range(0, 4) == 0;
            r = mkr($urandom_range(0, 9) == 0, !nw && !fw, !nw && fw, $urandom_range(0, 1) == 1,
                    5'($urandom_range(0, 7)), {$urandom(), $urandom()});
            step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, r, a);
        end
        idle(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
